// File: rtl/pulse_sync_pkg.sv
// -----------------------------------------------------------------------------
// pulse_sync_pkg
//   Shared definitions for the slow-domain pulse-synchronizer scheduler:
//   FSM state encodings and the synchronizer type-select codes.
// -----------------------------------------------------------------------------
package pulse_sync_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Synchronizer variant selected by sync_type_o.
  localparam logic TYPE_TOGGLE = 1'b0;
  localparam logic TYPE_CLAP   = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: returns the first set bit of
//   pending_i strictly after position rr_ptr_i, wrapping around.
// Ports
//   pending_i  [N_REQ-1:0]  requests awaiting service
//   rr_ptr_i   [IDX_W-1:0]  index granted last time (search starts after it)
//   gnt_o      [N_REQ-1:0]  one-hot grant (all zero when nothing pending)
//   idx_o      [IDX_W-1:0]  binary index of the grant
//   any_o                   at least one request pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic found;
  int   j;

  // Walk positions rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ); the last-granted
  // requester is visited last, so it only wins when it is alone.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(rr_ptr_i) + k) % N_REQ;
      if (!found && pending_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

  assign any_o = |pending_i;

endmodule

// File: rtl/pulse_sync_sched.sv
// -----------------------------------------------------------------------------
// pulse_sync_sched
//   Slow-domain scheduler sharing one pulse-synchronizer channel among N_REQ
//   requesters. Request pulses are latched, one is picked round-robin, the
//   channel type select is set one cycle ahead of a PULSE_W-cycle pulse, and a
//   GAP_W-cycle guard follows so consecutive pulses keep the synchronizer's
//   minimum spacing (PULSE_W+GAP_W+2 cycles between rises).
// Ports
//   clk_slow_i    single clock, rising edge
//   rst_n_i       synchronous active-low reset
//   en_i          1: new grants allowed; 0: finish in-flight sequence, then hold
//   req_i         per-requester event pulses (each high cycle = one event)
//   req_type_i    per-requester type select (0 toggle, 1 clap), sampled at grant
//   sync_in_o     pulse to the shared synchronizer input
//   sync_type_o   type select to the shared synchronizer
//   ack_o         one-hot 1-cycle pulse on the first pulse cycle of the grantee
//   busy_o        scheduler not idle
//   merge_cnt_o   saturating count of events merged into a pending request
// -----------------------------------------------------------------------------
module pulse_sync_sched
  import pulse_sync_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 1,
  parameter int GAP_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk_slow_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] req_type_i,
  output logic             sync_in_o,
  output logic             sync_type_o,
  output logic [N_REQ-1:0] ack_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] merge_cnt_o
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PH_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int SUM_W  = $clog2(N_REQ + 1);
  localparam int SAT_W  = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;

  // Phase counter holds "cycles remaining in this state minus one".
  localparam logic [PH_W-1:0]  PULSE_LOAD = PH_W'(PULSE_W - 1);
  localparam logic [PH_W-1:0]  GAP_LOAD   = PH_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               sync_in_q, sync_in_d;
  logic               sync_type_q, sync_type_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [CNT_W-1:0]   merge_cnt_q, merge_cnt_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [N_REQ-1:0]   clr;
  logic [N_REQ-1:0]   merge_hit;
  logic [SUM_W-1:0]   merge_sum;
  logic [SAT_W-1:0]   merge_ext;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .any_o     (arb_any)
  );

  // ---------------------------------------------------------------------------
  // Pending latch and merge detection. A request arriving on its own clear
  // edge survives (set wins), which schedules a follow-up pulse.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_pend
      assign pending_d[gi] = req_i[gi] | (pending_q[gi] & ~clr[gi]);
      assign merge_hit[gi] = req_i[gi] & pending_q[gi] & ~clr[gi];
    end
  endgenerate

  always_comb begin
    merge_sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (merge_hit[i]) merge_sum = merge_sum + SUM_W'(1);
    end
    // Widened add so several merges in one cycle saturate cleanly.
    merge_ext = SAT_W'(merge_cnt_q) + SAT_W'(merge_sum);
    if (merge_ext > SAT_W'(CNT_MAX)) merge_cnt_d = CNT_MAX;
    else                             merge_cnt_d = merge_ext[CNT_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and registered-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    sync_in_d   = sync_in_q;
    sync_type_d = sync_type_q;
    ack_d       = '0;
    clr         = '0;

    case (state_q)
      ST_IDLE: begin
        sync_in_d = 1'b0;
        if (en_i && arb_any) begin
          // Grant is committed on SETUP entry: type sampled here only, so
          // it is stable one cycle ahead of the pulse and through the guard.
          state_d     = ST_SETUP;
          phase_d     = '0;
          idx_d       = arb_idx;
          rr_ptr_d    = arb_idx;
          sync_type_d = req_type_i[arb_idx];
          clr         = arb_gnt;
        end
      end
      ST_SETUP: begin
        state_d       = ST_PULSE;
        phase_d       = PULSE_LOAD;
        sync_in_d     = 1'b1;
        ack_d[idx_q]  = 1'b1;
      end
      ST_PULSE: begin
        if (phase_q == '0) begin
          state_d   = ST_GAP;
          phase_d   = GAP_LOAD;
          sync_in_d = 1'b0;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_GAP: begin
        sync_in_d = 1'b0;
        if (phase_q == '0) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        phase_d   = '0;
        sync_in_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_slow_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      rr_ptr_q    <= IDX_W'(N_REQ - 1);
      sync_in_q   <= 1'b0;
      sync_type_q <= TYPE_TOGGLE;
      ack_q       <= '0;
      merge_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      sync_in_q   <= sync_in_d;
      sync_type_q <= sync_type_d;
      ack_q       <= ack_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

  assign sync_in_o   = sync_in_q;
  assign sync_type_o = sync_type_q;
  assign ack_o       = ack_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign merge_cnt_o = merge_cnt_q;

endmodule
